// File: rtl/tiny_nn_pkg.sv
// Shared definitions for the tiny_nn sequencer.
//
// Holds the 16-bit value type, the canonical quiet NaN used as the
// end-of-stream marker, the command opcodes decoded from data_i[15:12],
// the test-mode sub-opcodes decoded from data_i[11:8], and the sequencer
// state enum.
//
// Build option: TINY_NN_SEQ_TEST_MODES_EN adds the three test states to
// the enum. Without it those states do not exist.
package tiny_nn_pkg;

  typedef logic [15:0] fp_t;

  // Canonical half-precision quiet NaN; ends a convolve or accumulate stream.
  localparam fp_t FPStdNaN = 16'h7e00;

  localparam logic [3:0] CmdOpConvolve   = 4'h1;
  localparam logic [3:0] CmdOpAccumulate = 4'h2;
  localparam logic [3:0] CmdOpTest       = 4'hf;

  localparam logic [3:0] TestSubAscii = 4'hf;
  localparam logic [3:0] TestSubPulse = 4'h0;
  localparam logic [3:0] TestSubCount = 4'h1;

  typedef enum logic [3:0] {
    StIdle,
    StParamIn,
    StConvExec,
    StConvDrain,
    StBiasIn,
    StAccExec,
    StAccDrain
`ifdef TINY_NN_SEQ_TEST_MODES_EN
    ,
    StTestAscii,
    StTestPulse,
    StTestCount
`endif
  } state_e;

  // Byte loop emitted by the ASCII test mode.
  function automatic logic [7:0] ascii_byte(input logic [2:0] idx);
    case (idx)
      3'd0:    ascii_byte = 8'h54;
      3'd1:    ascii_byte = 8'h54;
      3'd2:    ascii_byte = 8'h2d;
      3'd3:    ascii_byte = 8'h4e;
      3'd4:    ascii_byte = 8'h4e;
      default: ascii_byte = 8'h54;
    endcase
  endfunction

endpackage

// File: rtl/tiny_nn_seq_out_mux.sv
// Result/test output selection for the tiny_nn sequencer.
//
// Purely combinational: picks what data_o shows from the sequencer state,
// row counter and group counter. Holds no state of its own.
//
// Ports:
//   i_state      - current sequencer state
//   i_row        - convolve row counter
//   i_count      - accumulate / drain / test counter
//   i_n          - captured accumulate group length
//   i_acc_result - accumulate result from the core
//   o_data       - OutWidth-bit result (all-ones when nothing to show)
//
// Build option: TINY_NN_SEQ_TEST_MODES_EN adds the test-mode bytes.
// The test bytes read i_count[7:0], so CountWidth must be at least 8.
module tiny_nn_seq_out_mux
  import tiny_nn_pkg::*;
#(
  parameter int CountWidth = 8,
  parameter int OutWidth   = 8,
  parameter int RowW       = 1
) (
  input  state_e                i_state,
  input  logic [RowW-1:0]       i_row,
  input  logic [CountWidth-1:0] i_count,
  input  logic [CountWidth-1:0] i_n,
  input  fp_t                   i_acc_result,
  output logic [OutWidth-1:0]   o_data
);

  localparam logic [RowW-1:0] RowOne = 1;

  logic [7:0] w_lo;
  logic [7:0] w_hi;

  assign w_lo = i_acc_result[7:0];
  assign w_hi = i_acc_result[15:8];

  always_comb begin
    o_data = '1;
    case (i_state)
      StConvExec, StConvDrain: begin
        // An 8-bit port needs two rows to carry one 16-bit result.
        if (OutWidth == 16) begin
          if (i_row == '0) o_data = OutWidth'(i_acc_result);
        end else begin
          if (i_row == '0)         o_data = OutWidth'(w_lo);
          else if (i_row == RowOne) o_data = OutWidth'(w_hi);
        end
      end
      StAccExec: begin
        if (OutWidth == 16) o_data = OutWidth'(i_acc_result);
        else                o_data = OutWidth'((i_count == i_n) ? w_lo : w_hi);
      end
      StAccDrain: begin
        if (OutWidth == 16) o_data = OutWidth'(i_acc_result);
        else                o_data = OutWidth'(i_count[0] ? w_lo : w_hi);
      end
`ifdef TINY_NN_SEQ_TEST_MODES_EN
      StTestAscii: o_data = OutWidth'(ascii_byte(i_count[2:0]));
      StTestPulse: o_data = OutWidth'(i_count[0] ? 8'h55 : 8'haa);
      StTestCount: o_data = OutWidth'(i_count[7:0]);
`endif
      default: o_data = '1;
    endcase
  end

endmodule

// File: rtl/tiny_nn_seq.sv
// Command sequencer for a tiny neural-network datapath core.
//
// data_i is sampled on every rising clock edge; there is no valid
// qualifier. In Idle its top nibble is a command; in the streaming states
// it is a parameter/operand word, and FPStdNaN marks the end of a stream.
// All control outputs are Moore outputs decoded from registered state.
//
// Ports:
//   clk_i, rst_ni           - clock, asynchronous active-low reset
//   data_i                  - command / parameter / operand word
//   acc_result_i            - accumulate result from the core
//   param_write_o           - one-hot parameter write strobe
//   val_shift_o             - one-hot value row shift
//   mul_row_sel_o, mul_en_o - multiplier row select and enable
//   acc_mode_0_en_o         - level-0 accumulate enables
//   acc_mode_1_en_o         - level-1 accumulate enables
//   acc_loopback_o          - accumulator loopback
//   acc_out_relu_o          - apply ReLU to the accumulator output
//   acc_level_0_en_o        - bias load
//   mul_add_op_a_en_o/_b_   - mul-add operand enables
//   data_o                  - result or test output
//   busy_o                  - high whenever not Idle
//
// Build option: TINY_NN_SEQ_TEST_MODES_EN enables the CmdOpTest modes
// (ASCII loop, 0xAA/0x55 pulse, countdown). Without it CmdOpTest is
// ignored. r_state is the FSM state for debug probing.
module tiny_nn_seq
  import tiny_nn_pkg::*;
#(
  parameter int ValArrayWidth  = 4,
  parameter int ValArrayHeight = 2,
  parameter int CountWidth     = 8,
  parameter int OutWidth       = 8
) (
  input  logic                                    clk_i,
  input  logic                                    rst_ni,
  input  logic [15:0]                             data_i,
  input  fp_t                                     acc_result_i,
  output logic [ValArrayWidth*ValArrayHeight-1:0] param_write_o,
  output logic [ValArrayHeight-1:0]               val_shift_o,
  output logic [$clog2(ValArrayHeight)-1:0]       mul_row_sel_o,
  output logic                                    mul_en_o,
  output logic [1:0]                              acc_mode_0_en_o,
  output logic [1:0]                              acc_mode_1_en_o,
  output logic                                    acc_loopback_o,
  output logic                                    acc_out_relu_o,
  output logic                                    acc_level_0_en_o,
  output logic                                    mul_add_op_a_en_o,
  output logic                                    mul_add_op_b_en_o,
  output logic [OutWidth-1:0]                     data_o,
  output logic                                    busy_o
);

  localparam int ParamW = ValArrayWidth * ValArrayHeight;
  localparam int RowW   = $clog2(ValArrayHeight);

  localparam logic [ParamW-1:0]         ParamFirst   = 1;
  localparam logic [ValArrayHeight-1:0] RowOneHot0   = 1;
  localparam logic [RowW-1:0]           RowOne       = 1;
  localparam logic [RowW-1:0]           LastRow      = RowW'(ValArrayHeight - 1);
  localparam logic [CountWidth-1:0]     CntOne       = 1;
  localparam logic [CountWidth-1:0]     CntTwo       = 2;
  // Drain counts 2H..0, i.e. 2H+1 further row cycles after the NaN.
  localparam logic [CountWidth-1:0]     ConvDrainLen = CountWidth'(2 * ValArrayHeight);

  state_e                  r_state;
  logic [CountWidth-1:0]   r_count;
  logic [CountWidth-1:0]   r_n;
  logic [RowW-1:0]         r_row;
  logic [ParamW-1:0]       r_param_write;
  logic                    r_relu;

  logic [3:0]              w_opcode;
  logic                    w_is_nan;
  logic [RowW-1:0]         w_row_next;

  assign w_opcode   = data_i[15:12];
  assign w_is_nan   = (data_i == FPStdNaN);
  assign w_row_next = (r_row == LastRow) ? '0 : r_row + RowOne;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state       <= StIdle;
      r_count       <= '0;
      r_n           <= '0;
      r_row         <= '0;
      r_param_write <= '0;
      r_relu        <= 1'b0;
    end else begin
      case (r_state)
        StIdle: begin
          r_row <= '0;
          case (w_opcode)
            CmdOpConvolve: begin
              r_param_write <= ParamFirst;
              r_state       <= StParamIn;
            end
            CmdOpAccumulate: begin
              r_n     <= data_i[CountWidth-1:0];
              r_relu  <= data_i[8];
              r_count <= CntOne;
              r_state <= StBiasIn;
            end
`ifdef TINY_NN_SEQ_TEST_MODES_EN
            CmdOpTest: begin
              case (data_i[11:8])
                TestSubAscii: begin
                  r_count <= '0;
                  r_state <= StTestAscii;
                end
                TestSubPulse: begin
                  r_count <= '0;
                  r_state <= StTestPulse;
                end
                TestSubCount: begin
                  r_count <= CountWidth'(data_i[7:0]);
                  r_state <= StTestCount;
                end
                default: r_state <= StIdle;
              endcase
            end
`endif
            default: r_state <= StIdle;
          endcase
        end

        StParamIn: begin
          // The cycle showing the MSB strobe is the last parameter write.
          if (r_param_write[ParamW-1]) begin
            r_param_write <= '0;
            r_state       <= StConvExec;
          end else begin
            r_param_write <= r_param_write << 1;
          end
        end

        StConvExec: begin
          r_row <= w_row_next;
          if (w_is_nan) begin
            r_count <= ConvDrainLen;
            r_state <= StConvDrain;
          end
        end

        StConvDrain: begin
          r_row <= w_row_next;
          if (r_count == '0) r_state <= StIdle;
          else               r_count <= r_count - CntOne;
        end

        StBiasIn: begin
          // The bias cycle consumes the initial count of 1, so AccExec
          // opens on a group boundary.
          r_count <= r_count - CntOne;
          r_state <= StAccExec;
        end

        StAccExec: begin
          if (r_count == '0) begin
            r_count <= r_n;
          end else if (w_is_nan) begin
            r_count <= CntTwo;
            r_state <= StAccDrain;
          end else begin
            r_count <= r_count - CntOne;
          end
        end

        StAccDrain: begin
          r_count <= r_count - CntOne;
          if (r_count == '0) r_state <= StIdle;
        end

`ifdef TINY_NN_SEQ_TEST_MODES_EN
        StTestAscii: begin
          if (data_i[15:8] == 8'hff)
            r_count <= (r_count == CountWidth'(4)) ? '0 : r_count + CntOne;
          else
            r_state <= StIdle;
        end

        StTestPulse: begin
          // Bit 0 of the counter selects 0xAA / 0x55.
          if (data_i[15:8] == 8'hf0) r_count <= r_count + CntOne;
          else                       r_state <= StIdle;
        end

        StTestCount: begin
          if (r_count == '0) r_state <= StIdle;
          else               r_count <= r_count - CntOne;
        end
`endif

        default: r_state <= StIdle;
      endcase
    end
  end

  always_comb begin
    val_shift_o       = '0;
    mul_row_sel_o     = '0;
    mul_en_o          = 1'b0;
    acc_mode_0_en_o   = 2'b00;
    acc_mode_1_en_o   = 2'b00;
    acc_loopback_o    = 1'b0;
    acc_out_relu_o    = 1'b0;
    acc_level_0_en_o  = 1'b0;
    mul_add_op_a_en_o = 1'b0;
    mul_add_op_b_en_o = 1'b0;
    case (r_state)
      StConvExec, StConvDrain: begin
        val_shift_o     = RowOneHot0 << r_row;
        mul_row_sel_o   = r_row;
        mul_en_o        = 1'b1;
        acc_mode_0_en_o = {(r_row != '0), 1'b1};
      end
      StBiasIn: acc_level_0_en_o = 1'b1;
      StAccExec: begin
        acc_mode_1_en_o[0] = 1'b1;
        mul_add_op_b_en_o  = 1'b1;
        acc_out_relu_o     = r_relu;
        if (r_count == '0) begin
          acc_mode_1_en_o[1] = 1'b1;
        end else begin
          acc_loopback_o    = 1'b1;
          mul_add_op_a_en_o = (r_count == CntOne);
        end
      end
      StAccDrain: acc_mode_1_en_o[1] = (r_count == CntTwo);
      default: ;
    endcase
  end

  assign param_write_o = r_param_write;
  assign busy_o        = (r_state != StIdle);

  tiny_nn_seq_out_mux #(
    .CountWidth (CountWidth),
    .OutWidth   (OutWidth),
    .RowW       (RowW)
  ) u_out_mux (
    .i_state      (r_state),
    .i_row        (r_row),
    .i_count      (r_count),
    .i_n          (r_n),
    .i_acc_result (acc_result_i),
    .o_data       (data_o)
  );

endmodule

// File: tb/tb_tiny_nn_seq.sv
// Bench for tiny_nn_seq: two instances (8-bit and 16-bit data_o, both with
// a 4x4 value array) share the stimulus. Each driven cycle pushes the
// expected output vector; it is popped and compared mid-cycle.
module tb_tiny_nn_seq;
  import tiny_nn_pkg::*;

  localparam int OBS_W = 57;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [15:0] data_i = '0;
  fp_t         acc_result = '0;

  logic [15:0] pw, pw_16;
  logic [3:0]  vs, vs_16;
  logic [1:0]  rs, rs_16;
  logic        me, me_16;
  logic [1:0]  m0, m0_16, m1, m1_16;
  logic        lb, lb_16, relu, relu_16, l0, l0_16, oa, oa_16, ob, ob_16;
  logic [7:0]  d8;
  logic [15:0] d16;
  logic        busy, busy_16;

  tiny_nn_seq #(.ValArrayWidth(4), .ValArrayHeight(4), .CountWidth(8), .OutWidth(8)) dut (
    .clk_i(clk), .rst_ni(rst_n), .data_i(data_i), .acc_result_i(acc_result),
    .param_write_o(pw), .val_shift_o(vs), .mul_row_sel_o(rs), .mul_en_o(me),
    .acc_mode_0_en_o(m0), .acc_mode_1_en_o(m1), .acc_loopback_o(lb),
    .acc_out_relu_o(relu), .acc_level_0_en_o(l0), .mul_add_op_a_en_o(oa),
    .mul_add_op_b_en_o(ob), .data_o(d8), .busy_o(busy)
  );

  tiny_nn_seq #(.ValArrayWidth(4), .ValArrayHeight(4), .CountWidth(8), .OutWidth(16)) dut16 (
    .clk_i(clk), .rst_ni(rst_n), .data_i(data_i), .acc_result_i(acc_result),
    .param_write_o(pw_16), .val_shift_o(vs_16), .mul_row_sel_o(rs_16), .mul_en_o(me_16),
    .acc_mode_0_en_o(m0_16), .acc_mode_1_en_o(m1_16), .acc_loopback_o(lb_16),
    .acc_out_relu_o(relu_16), .acc_level_0_en_o(l0_16), .mul_add_op_a_en_o(oa_16),
    .mul_add_op_b_en_o(ob_16), .data_o(d16), .busy_o(busy_16)
  );

  // ---------------- scoreboard ----------------
  int n_checks = 0;
  int n_errors = 0;
  logic [OBS_W-1:0] exp_q[$];

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  function automatic logic [OBS_W-1:0] mk(
    input logic b, input logic [15:0] p, input logic [3:0] v, input logic [1:0] r,
    input logic e, input logic [1:0] a0, input logic [1:0] a1, input logic lp,
    input logic rl, input logic bl, input logic opa, input logic opb,
    input logic [7:0] o8, input logic [15:0] o16);
    return {b, p, v, r, e, a0, a1, lp, rl, bl, opa, opb, o8, o16};
  endfunction

  function automatic logic [OBS_W-1:0] obs();
    return {busy, pw, vs, rs, me, m0, m1, lb, relu, l0, oa, ob, d8, d16};
  endfunction

  function automatic logic [OBS_W-1:0] exp_idle();
    return mk(0, 16'h0, 4'h0, 2'd0, 0, 2'b00, 2'b00, 0, 0, 0, 0, 0, 8'hff, 16'hffff);
  endfunction

  function automatic logic [OBS_W-1:0] exp_param(input int k);
    logic [15:0] oh;
    oh = 16'h1 << k;
    return mk(1, oh, 4'h0, 2'd0, 0, 2'b00, 2'b00, 0, 0, 0, 0, 0, 8'hff, 16'hffff);
  endfunction

  function automatic logic [OBS_W-1:0] exp_conv(input int r, input fp_t a);
    logic [3:0] oh;
    logic [7:0] o8;
    logic [15:0] o16;
    oh  = 4'h1 << r;
    o8  = (r == 0) ? a[7:0] : (r == 1) ? a[15:8] : 8'hff;
    o16 = (r == 0) ? a : 16'hffff;
    return mk(1, 16'h0, oh, 2'(r), 1, {r != 0, 1'b1}, 2'b00, 0, 0, 0, 0, 0, o8, o16);
  endfunction

  function automatic logic [OBS_W-1:0] exp_acc(input int c, input int n, input logic rl, input fp_t a);
    logic [7:0] o8;
    o8 = (c == n) ? a[7:0] : a[15:8];
    return mk(1, 16'h0, 4'h0, 2'd0, 0, 2'b00, {c == 0, 1'b1}, c != 0, rl, 0, c == 1, 1, o8, a);
  endfunction

  function automatic logic [OBS_W-1:0] exp_drain(input int c, input fp_t a);
    logic [7:0] o8;
    o8 = (c % 2 == 1) ? a[7:0] : a[15:8];
    return mk(1, 16'h0, 4'h0, 2'd0, 0, 2'b00, {c == 2, 1'b0}, 0, 0, 0, 0, 0, o8, a);
  endfunction

  function automatic logic [OBS_W-1:0] exp_test(input logic [7:0] b);
    return mk(1, 16'h0, 4'h0, 2'd0, 0, 2'b00, 2'b00, 0, 0, 0, 0, 0, b, {8'h00, b});
  endfunction

  function automatic logic [OBS_W-1:0] exp_bias();
    return mk(1, 16'h0, 4'h0, 2'd0, 0, 2'b00, 2'b00, 0, 0, 1, 0, 0, 8'hff, 16'hffff);
  endfunction

  // ---------------- driver ----------------
  // Inputs change 1 time unit after the rising edge; data_i is consumed at
  // the following edge. Outputs for the cycle are compared at the falling edge.
  task automatic drive_cycle(input string tag, input logic [15:0] d, input fp_t a,
                             input logic [OBS_W-1:0] e);
    @(posedge clk);
    #1;
    data_i = d;
    acc_result = a;
    exp_q.push_back(e);
    @(negedge clk);
    check(tag, 64'(obs()), 64'(exp_q.pop_front()));
  endtask

  function automatic logic [15:0] operand();
    return 16'($urandom_range(0, 16'h7bff));
  endfunction

  // ---------------- stimulus ----------------
  initial begin
    fp_t a;
    int c;
    logic [7:0] ascii_tab [5];
    ascii_tab = '{8'h54, 8'h54, 8'h2d, 8'h4e, 8'h4e};

    // Reset state
    repeat (3) @(negedge clk);
    check("reset_outputs", 64'(obs()), 64'(exp_idle()));
    check("reset_busy16", 64'(busy_16), 64'(0));
    #1 rst_n = 1'b1;

    // Non-commands leave the block idle
    drive_cycle("illegal_op", 16'h3000, 16'h1234, exp_idle());
    drive_cycle("idle_nan", FPStdNaN, 16'h1234, exp_idle());
    drive_cycle("idle_hold", 16'h0000, 16'h1234, exp_idle());

    // Convolve: 16 parameters, 8 operands, NaN, 9 drain cycles
    drive_cycle("conv_cmd", 16'h1000, 16'h0, exp_idle());
    for (int k = 0; k < 16; k++)
      drive_cycle("conv_param", 16'($urandom), 16'($urandom), exp_param(k));
    for (int k = 0; k < 18; k++) begin
      a = 16'($urandom);
      if (k == 5) a = 16'h3c00;
      drive_cycle("conv_exec", (k == 8) ? FPStdNaN : operand(), a, exp_conv(k % 4, a));
    end
    drive_cycle("conv_done", 16'h0000, 16'h3c00, exp_idle());

    // Reset lands mid-ParamIn, then Accumulate N=3 relu=1
    drive_cycle("conv2_cmd", 16'h1000, 16'h0, exp_idle());
    for (int k = 0; k < 3; k++)
      drive_cycle("conv2_param", 16'($urandom), 16'h0, exp_param(k));
    #2 rst_n = 1'b0;
    #1;
    check("rst_mid_busy", 64'(busy), 64'(0));
    check("rst_mid_pw", 64'(pw), 64'(0));
    check("rst_mid_d8", 64'(d8), 64'(8'hff));
    check("rst_mid_d16", 64'(d16), 64'(16'hffff));
    drive_cycle("rst_hold", 16'h1000, 16'h5555, exp_idle());
    drive_cycle("acc_cmd", 16'h2103, 16'h5555, exp_idle());
    #1 rst_n = 1'b1;
    drive_cycle("acc_bias", operand(), 16'($urandom), exp_bias());
    c = 0;
    for (int k = 0; k < 7; k++) begin
      a = 16'($urandom);
      drive_cycle("acc3_exec", (k == 6) ? FPStdNaN : operand(), a, exp_acc(c, 3, 1'b1, a));
      c = (c == 0) ? 3 : c - 1;
    end
    for (int k = 2; k >= 0; k--) begin
      a = 16'($urandom);
      drive_cycle("acc3_drain", operand(), a, exp_drain(k, a));
    end
    drive_cycle("acc3_done", 16'h0000, 16'h0, exp_idle());

    // Accumulate N=0: every cycle is a group boundary, NaN never drains
    drive_cycle("acc0_cmd", 16'h2000, 16'h0, exp_idle());
    drive_cycle("acc0_bias", operand(), 16'h0, exp_bias());
    for (int k = 0; k < 8; k++) begin
      a = 16'($urandom);
      drive_cycle("acc0_exec", (k == 4) ? FPStdNaN : operand(), a, exp_acc(0, 0, 1'b0, a));
    end
    #2 rst_n = 1'b0;
    #1;
    check("rst_acc_busy", 64'(busy), 64'(0));
    check("rst_acc_m1", 64'(m1), 64'(0));
    check("rst_acc_opb", 64'(ob), 64'(0));
    @(negedge clk);
    #1 rst_n = 1'b1;
    drive_cycle("acc0_after_rst", 16'h0000, 16'h0, exp_idle());

`ifdef TINY_NN_SEQ_TEST_MODES_EN
    drive_cycle("cnt_cmd", 16'hf105, 16'h0, exp_idle());
    for (int v = 5; v >= 0; v--)
      drive_cycle("test_count", 16'h0000, 16'($urandom), exp_test(8'(v)));
    drive_cycle("cnt_done", 16'h0000, 16'h0, exp_idle());

    drive_cycle("ascii_cmd", 16'hff00, 16'h0, exp_idle());
    for (int k = 0; k < 7; k++)
      drive_cycle("test_ascii", (k < 6) ? 16'hff00 : 16'h0000, 16'h0, exp_test(ascii_tab[k % 5]));
    drive_cycle("ascii_done", 16'h0000, 16'h0, exp_idle());

    drive_cycle("pulse_cmd", 16'hf000, 16'h0, exp_idle());
    for (int k = 0; k < 4; k++)
      drive_cycle("test_pulse", (k < 3) ? 16'hf000 : 16'h0000, 16'h0,
                  exp_test((k % 2 == 0) ? 8'haa : 8'h55));
    drive_cycle("pulse_done", 16'h0000, 16'h0, exp_idle());
`else
    drive_cycle("cnt_cmd", 16'hf105, 16'h0, exp_idle());
    for (int k = 0; k < 6; k++)
      drive_cycle("test_ignored", 16'h0000, 16'h0, exp_idle());
    drive_cycle("ascii_cmd", 16'hff00, 16'h0, exp_idle());
    drive_cycle("ascii_ignored", 16'hff00, 16'h0, exp_idle());
`endif

    check("sb_empty", 64'(exp_q.size()), 64'(0));
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
